// File: rtl/rr_arb8_ctrl_pkg.sv
// Shared definitions for the eight-way round-robin arbiter.
// Holds the requester count, the arbiter state enum and the rotating priority pick.
package rr_arb8_ctrl_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // First set bit of req searching base, base+1, ... with wrap mod 8.
    // The loop runs from the farthest offset down so the nearest hit is written last.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] base);
        pick_t            p;
        logic [SEL_W-1:0] idx;
        p = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            idx = base + SEL_W'(i);
            if (req[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arb8_ctrl_mux8.sv
// Eight-input payload multiplexer.
// Ports: d0..d7 payload inputs, sel 3-bit select, y selected payload.
module rr_arb8_ctrl_mux8 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            3'd0: y = d0;
            3'd1: y = d1;
            3'd2: y = d2;
            3'd3: y = d3;
            3'd4: y = d4;
            3'd5: y = d5;
            3'd6: y = d6;
            3'd7: y = d7;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter/sequencer sharing one valid/ready port among eight requesters.
// A grant is held for a whole multi-beat transaction; handover to the next requester
// happens on the completing beat with no idle cycle.
// Ports: clk, rst (sync, active-high); req/last per requester; data0..data7 payloads;
// out_ready from downstream; out_valid/out_last/out_data to downstream;
// grant one-hot, ack per-requester beat strobe, sel encoded grant, busy.
module rr_arb8_ctrl
    import rr_arb8_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     last,
    input  logic [WIDTH-1:0]     data0,
    input  logic [WIDTH-1:0]     data1,
    input  logic [WIDTH-1:0]     data2,
    input  logic [WIDTH-1:0]     data3,
    input  logic [WIDTH-1:0]     data4,
    input  logic [WIDTH-1:0]     data5,
    input  logic [WIDTH-1:0]     data6,
    input  logic [WIDTH-1:0]     data7,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [WIDTH-1:0]     out_data,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     ack,
    output logic [SEL_W-1:0]     sel,
    output logic                 busy
);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] next_base;
    logic             done;
    pick_t            idle_pick;
    pick_t            next_pick;

    // Downstream view is steered by the registered select
    assign busy      = (state == BUSY);
    assign out_valid = busy & req[sel];
    assign out_last  = busy & last[sel];
    assign ack       = grant & {N_REQ{out_valid & out_ready}};
    assign done      = out_valid & out_ready & out_last;

    // Fresh arbitration from idle, and handover arbitration excluding the finishing owner
    assign next_base = sel + SEL_W'(1);
    assign idle_pick = rr_pick(req, ptr);
    assign next_pick = rr_pick(req & ~grant, next_base);

    // Arbiter state, pointer and grant registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            grant <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_pick.found) begin
                        sel   <= idle_pick.idx;
                        grant <= N_REQ'(1) << idle_pick.idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        ptr <= next_base;
                        if (next_pick.found) begin
                            sel   <= next_pick.idx;
                            grant <= N_REQ'(1) << next_pick.idx;
                        end else begin
                            grant <= '0;
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    rr_arb8_ctrl_mux8 #(
        .WIDTH(WIDTH)
    ) u_mux (
        .d0 (data0),
        .d1 (data1),
        .d2 (data2),
        .d3 (data3),
        .d4 (data4),
        .d5 (data5),
        .d6 (data6),
        .d7 (data7),
        .sel(sel),
        .y  (out_data)
    );

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Testbench for rr_arb8_ctrl: directed scenarios plus randomized burst traffic,
// checked every cycle against a transaction-level reference model.
module tb_rr_arb8_ctrl;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       req;
    logic [7:0]       last;
    logic [WIDTH-1:0] d [8];
    logic             out_ready;
    logic             out_valid;
    logic             out_last;
    logic [WIDTH-1:0] out_data;
    logic [7:0]       grant;
    logic [7:0]       ack;
    logic [2:0]       sel;
    logic             busy;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port, whether it is owned, rotating base
    bit         m_busy;
    int         m_owner;
    int         m_ptr;
    logic [7:0] m_ack;
    int         rem [8];

    always #5 clk = ~clk;

    rr_arb8_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .last     (last),
        .data0    (d[0]),
        .data1    (d[1]),
        .data2    (d[2]),
        .data3    (d[3]),
        .data4    (d[4]),
        .data5    (d[5]),
        .data6    (d[6]),
        .data7    (d[7]),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_data (out_data),
        .grant    (grant),
        .ack      (ack),
        .sel      (sel),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model at posedge
    task automatic step(input logic [7:0] r, input logic [7:0] l, input logic rdy, input logic rs);
        logic [7:0] eg;
        logic       ev;
        logic       el;
        int         idx;
        bit         found;
        @(negedge clk);
        req = r; last = l; out_ready = rdy; rst = rs;
        for (int i = 0; i < 8; i++) d[i] = $urandom;
        #1;
        eg    = m_busy ? (8'(1) << m_owner) : 8'h00;
        ev    = m_busy && r[m_owner];
        el    = m_busy && l[m_owner];
        m_ack = (ev && rdy) ? eg : 8'h00;
        chk("grant", 64'(grant), 64'(eg));
        chk("sel", 64'(sel), 64'(m_owner));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("out_last", 64'(out_last), 64'(el));
        chk("out_data", 64'(out_data), 64'(d[m_owner]));
        chk("ack", 64'(ack), 64'(m_ack));
        @(posedge clk);
        if (rs) begin
            m_busy = 0; m_ptr = 0; m_owner = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < 8; k++) begin
                idx = (m_ptr + k) % 8;
                if (r[idx] && !m_busy) begin
                    m_busy = 1; m_owner = idx;
                end
            end
        end else if (ev && rdy && el) begin
            m_ptr = (m_owner + 1) % 8;
            found = 0;
            for (int k = 0; k < 8; k++) begin
                idx = (m_ptr + k) % 8;
                if (!found && idx != m_owner && r[idx]) begin
                    found = 1; m_owner = idx;
                end
            end
            if (!found) m_busy = 0;
        end
    endtask

    // Requesters that honour the protocol: each holds req for its remaining beat count
    task automatic rr_cycle(input logic rdy, input bit allow_new);
        logic [7:0] r;
        logic [7:0] l;
        for (int i = 0; i < 8; i++) begin
            if (rem[i] == 0 && allow_new && $urandom_range(0, 3) == 0)
                rem[i] = $urandom_range(1, 4);
            r[i] = (rem[i] > 0);
            l[i] = (rem[i] == 1);
        end
        step(r, l, rdy, 1'b0);
        for (int i = 0; i < 8; i++) if (m_ack[i]) rem[i]--;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 8; i++) rem[i] = 0;
        step(8'h00, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        int left;
        rst = 1; req = 0; last = 0; out_ready = 0;
        for (int i = 0; i < 8; i++) begin d[i] = 0; rem[i] = 0; end
        m_busy = 0; m_owner = 0; m_ptr = 0; m_ack = 0;
        repeat (2) @(posedge clk);

        // Single-beat request from requester 2
        step(8'h00, 8'h00, 1'b1, 1'b0);
        step(8'h04, 8'h04, 1'b1, 1'b0);
        #2;
        chk("s1_grant", 64'(grant), 64'h04);
        chk("s1_sel", 64'(sel), 64'd2);
        chk("s1_valid", 64'(out_valid), 64'd1);
        chk("s1_ack", 64'(ack), 64'h04);
        step(8'h04, 8'h04, 1'b1, 1'b0);
        #2;
        chk("s1_idle_grant", 64'(grant), 64'h00);
        step(8'h00, 8'h00, 1'b1, 1'b0);

        // All eight requesting single beats: strict rotation 0..7,0
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(8'hFF, 8'hFF, 1'b1, 1'b0);
            #2;
            chk("rot_grant", 64'(grant), 64'(8'(1) << (k % 8)));
        end

        // Two 4-beat bursts from 1 and 6 with out_ready toggling
        do_reset();
        rem[1] = 4; rem[6] = 4;
        rr_cycle(1'b1, 1'b0);
        #2;
        chk("burst_first", 64'(grant), 64'h02);
        for (int c = 0; c < 40 && (rem[1] + rem[6]) > 0; c++)
            rr_cycle((c % 2) == 0, 1'b0);
        chk("burst_done", 64'(rem[1] + rem[6]), 64'd0);

        // Requester 5 drops req mid-burst, grant is held
        do_reset();
        step(8'h20, 8'h00, 1'b1, 1'b0);
        step(8'h20, 8'h00, 1'b1, 1'b0);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        #2;
        chk("drop_valid", 64'(out_valid), 64'd0);
        chk("drop_grant", 64'(grant), 64'h20);
        chk("drop_ack", 64'(ack), 64'h00);
        step(8'h20, 8'h20, 1'b1, 1'b0);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        #2;
        chk("drop_end_grant", 64'(grant), 64'h00);

        // Reset during the second beat of requester 3's burst
        do_reset();
        step(8'h08, 8'h00, 1'b1, 1'b0);
        step(8'h08, 8'h00, 1'b1, 1'b0);
        step(8'h08, 8'h00, 1'b1, 1'b1);
        #2;
        chk("rst_grant", 64'(grant), 64'h00);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sel", 64'(sel), 64'd0);
        step(8'h08, 8'h00, 1'b1, 1'b0);
        #2;
        chk("rst_regrant", 64'(grant), 64'h08);

        // Pointer wrap: after requester 6, 7 wins before 0
        do_reset();
        step(8'h40, 8'h40, 1'b1, 1'b0);
        step(8'h40, 8'h40, 1'b1, 1'b0);
        step(8'h81, 8'h81, 1'b1, 1'b0);
        #2;
        chk("wrap_7", 64'(grant), 64'h80);
        step(8'h81, 8'h81, 1'b1, 1'b0);
        #2;
        chk("wrap_0", 64'(grant), 64'h01);
        step(8'h00, 8'h00, 1'b1, 1'b0);

        // Random protocol-compliant traffic, then drain
        do_reset();
        for (int c = 0; c < 1500; c++)
            rr_cycle(1'($urandom_range(0, 1)), 1'b1);
        for (int c = 0; c < 200; c++)
            rr_cycle(1'b1, 1'b0);
        left = 0;
        for (int i = 0; i < 8; i++) left += rem[i];
        chk("drain", 64'(left), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
